sky130_sram_port0_ctrl: RTL and testbench
=========================================

Name: sky130_sram_port0_ctrl

Overview:
- Request/response front end for the RW port (port 0) of the 32x512 OpenRAM SRAM macro.
- Sits directly upstream of the macro.
- Accepts read/write commands over a valid/ready interface and drives the macro's registered port-0 pins (csb0, web0, wmask0, addr0, din0).
- Captures dout0 after the macro's negedge read and returns read data in order through a response FIFO with backpressure.

Parameters:
- DATA_WIDTH, 32, data word width; must match the macro.
- ADDR_WIDTH, 9, word address width.
- NUM_WMASKS, 4, byte-lane write-mask bits (DATA_WIDTH/8).
- RSP_DEPTH, 4, response FIFO entries; power of two, at least 2.

Ports:
- clk0  in  1  clock, shared with the macro's clk0.
- rstb0  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge clk0.
- req_we  in  1  1 = write, 0 = read.
- req_wmask  in  NUM_WMASKS  byte-lane enables for writes.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response FIFO non-empty.
- rsp_ready  in  1  consumer pops when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  FIFO head read data.
- sram_csb0  out  1  to macro csb0 (active low).
- sram_web0  out  1  to macro web0 (active low).
- sram_wmask0  out  NUM_WMASKS  to macro wmask0.
- sram_addr0  out  ADDR_WIDTH  to macro addr0.
- sram_din0  out  DATA_WIDTH  to macro din0.
- sram_dout0  in  DATA_WIDTH  from macro dout0.

Behaviour:
- All sram_* outputs are flops on posedge clk0. The macro samples them on the following posedge.
- Reset values (asynchronous, rstb0 low):
  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
  - rsp_valid=0, FIFO empty, in-flight flags cleared.
  - req_ready=1 once rstb0 is high.
- Pipeline stage S1, posedge k accepting a request:
  - sram_csb0<=0, sram_web0<=~req_we, sram_addr0<=req_addr, sram_din0<=req_wdata.
  - sram_wmask0<=req_wmask for writes, 0 for reads.
  - rd_s1<=~req_we.
- Pipeline stage S2, posedge k+1:
  - The macro registers the command. For a read, the macro updates dout0 at negedge k+1.
  - rd_s2<=rd_s1.
- Capture, posedge k+2: if rd_s2, push sram_dout0 into the FIFO. rsp_valid is high after posedge k+2.
  - Read latency = 2 cycles from acceptance to rsp_valid when the FIFO is empty.
- No request accepted at a posedge: sram_csb0<=1, sram_web0<=1, sram_wmask0<=0. Addr and din hold their previous values.
- Throughput: one request per cycle, reads and writes in any mix. Commands reach the macro in acceptance order, so read-after-write to the same address returns the new data.
- Writes produce no response and need no credit.
- Credit rule: req_ready = req_we_is_write_ok || (rd_s1 + rd_s2 + fifo_count < RSP_DEPTH).
  - For writes, req_ready=1 always.
  - req_ready depends only on state and req_we, never on rsp_ready (no combinational path from rsp_ready).
  - Guarantees a push never overflows the FIFO.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo RSP_DEPTH.
  - rsp_rdata is the head entry, stable while rsp_valid && !rsp_ready.
- Address has no special handling. Address 511 and address 0 are ordinary, with no wrap semantics in the controller.
- Reset mid-operation:
  - In-flight reads and FIFO contents are discarded. No response is ever produced for them.
  - sram_csb0 goes to 1 immediately.
  - A write already registered inside the macro at reset assertion is allowed to complete and is not reported.
- When req_valid is low, req_* values are don't-care and have no effect.

Optional Feature:
- Macro name: SRAM_CTRL_WRITE_ACK_EN.
- When defined:
  - Every accepted write also produces a response entry at the same 2-cycle latency, with rsp_rdata=0.
  - An extra output port rsp_is_write (1 bit) is added; it is 1 for write acks and 0 for read data.
  - Writes consume credit like reads, so req_ready follows the credit rule for both read and write requests.
- When undefined:
  - No rsp_is_write port.
  - Writes are never acknowledged.
  - Write acceptance ignores credit.

Test Plan:
- Write then read back:
  - Stimulus: write addr 5 = 0xDEADBEEF, mask 0xF, then read addr 5 next cycle, rsp_ready=1.
  - Response: rsp_valid exactly 2 cycles after read acceptance with rsp_rdata=0xDEADBEEF. sram_csb0 is low for exactly 2 cycles.
- Byte mask:
  - Stimulus: write addr 7 = 0x11223344 mask 0xF, then write 0xAABBCCDD mask 0x5, then read addr 7.
  - Response: rsp_rdata=0x11BB33DD.
- Backpressure:
  - Stimulus: rsp_ready=0, 6 back-to-back reads of addr 0..5 (preloaded with value = addr).
  - Response: exactly 4 reads accepted, then req_ready=0. A write issued while stalled is still accepted.
  - Then raise rsp_ready: data 0,1,2,3 pops in order, and the remaining reads are accepted and return 4,5.
- Simultaneous push/pop and wrap:
  - Stimulus: continuous reads of addr 511,0,1,… with rsp_ready=1 for 20 cycles.
  - Response: one response per cycle after a 2-cycle fill, in order, FIFO count never exceeding 1, and the FIFO pointer wraps cleanly.
- Reset mid-burst:
  - Stimulus: rstb0 low for 1 cycle while 2 reads are in flight and 2 entries sit in the FIFO.
  - Response: sram_csb0=1 and rsp_valid=0 immediately, req_ready=1 after release, and no stale response ever appears.
- Feature enabled (SRAM_CTRL_WRITE_ACK_EN):
  - Stimulus: write then read, rsp_ready=1.
  - Response: two responses in order, {rsp_is_write=1, rsp_rdata=0} then {rsp_is_write=0, data}. With rsp_ready=0, req_ready drops after 4 writes.

Source files
------------

// File: rtl/sky130_sram_port0_ctrl_if.sv
// Request/response bundle for the sky130 SRAM port-0 controller.
// rsp_is_write exists only when SRAM_CTRL_WRITE_ACK_EN is defined.
interface sky130_sram_port0_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
`ifdef SRAM_CTRL_WRITE_ACK_EN
  logic                  rsp_is_write;
`endif

  modport master (
    output req_valid, req_we, req_wmask,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
`ifdef SRAM_CTRL_WRITE_ACK_EN
    input  rsp_is_write,
`endif
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_we, req_wmask,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata,
`ifdef SRAM_CTRL_WRITE_ACK_EN
    output rsp_is_write,
`endif
    input  rsp_ready
  );
endinterface

// File: rtl/sky130_sram_port0_ctrl.sv
// Port-0 front end for the 32x512 OpenRAM macro: registered pins, response FIFO.
// Optional write acks via `define SRAM_CTRL_WRITE_ACK_EN.
module sky130_sram_port0_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  sky130_sram_port0_ctrl_if.slave bus,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic                  rd_s1_q;
  logic                  rd_s2_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wp_q, rp_q;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] push_data;
  logic [CW-1:0]         pending;
  logic                  credit_ok;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  rsp_s1;

  assign pending = CW'(rd_s1_q)
                 + CW'(rd_s2_q)
                 + cnt_q;
  assign credit_ok = pending < DEPTH_C;

`ifdef SRAM_CTRL_WRITE_ACK_EN
  logic                 wr_s1_q;
  logic                 wr_s2_q;
  logic [RSP_DEPTH-1:0] fwr_q;

  assign bus.req_ready = credit_ok;
  assign rsp_s1        = accept;
  assign push_data     = wr_s2_q ? '0
                                 : sram_dout0;

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      wr_s1_q <= 1'b0;
      wr_s2_q <= 1'b0;
      fwr_q   <= '0;
    end else begin
      wr_s1_q <= accept & bus.req_we;
      wr_s2_q <= wr_s1_q;
      if (push) fwr_q[wp_q] <= wr_s2_q;
    end
  end

  assign bus.rsp_is_write = fwr_q[rp_q];
`else
  assign bus.req_ready = bus.req_we | credit_ok;
  assign rsp_s1        = accept & ~bus.req_we;
  assign push_data     = sram_dout0;
`endif

  assign accept = bus.req_valid & bus.req_ready;
  assign push   = rd_s2_q;
  assign pop    = bus.rsp_valid & bus.rsp_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      rd_s1_q     <= 1'b0;
      rd_s2_q     <= 1'b0;
    end else begin
      sram_csb0   <= ~accept;
      sram_web0   <= ~(accept & bus.req_we);
      sram_wmask0 <= (accept & bus.req_we)
                     ? bus.req_wmask : '0;
      if (accept) begin
        sram_addr0 <= bus.req_addr;
        sram_din0  <= bus.req_wdata;
      end
      rd_s1_q <= rsp_s1;
      rd_s2_q <= rd_s1_q;
    end
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
    end
  end

  // Storage needs no reset: entries are only visible behind cnt_q.
  always_ff @(posedge clk0) begin
    if (push) fifo_q[wp_q] <= push_data;
  end

  assign bus.rsp_valid = cnt_q != '0;
  assign bus.rsp_rdata = fifo_q[rp_q];

endmodule

// File: tb/tb_sky130_sram_port0_ctrl.sv
// Directed bench for sky130_sram_port0_ctrl with a behavioural port-0 macro.
// Define SRAM_CTRL_WRITE_ACK_EN to exercise write acks.
module tb_sky130_sram_port0_ctrl;

  logic        clk0 = 1'b0;
  logic        rstb0;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  int n_vec = 0;
  int n_err = 0;

  sky130_sram_port0_ctrl_if #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(9),
    .NUM_WMASKS(4)
  ) bus ();

  sky130_sram_port0_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(9),
    .NUM_WMASKS(4),
    .RSP_DEPTH (4)
  ) dut (
    .clk0       (clk0),
    .rstb0      (rstb0),
    .bus        (bus.slave),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  always #5 clk0 = ~clk0;

  // Macro model: pins sampled on posedge, read data driven on negedge.
  logic [31:0] mem [512];
  logic        init_done = 1'b0;
  logic        rd_pend = 1'b0;
  logic [8:0]  rd_addr = '0;

  always @(posedge clk0) begin
    if (!init_done) begin
      for (int i = 0; i < 512; i++)
        mem[i] <= 32'h5A00_0000 | 32'(i);
      init_done <= 1'b1;
    end else if (!sram_csb0 && !sram_web0) begin
      for (int b = 0; b < 4; b++)
        if (sram_wmask0[b])
          mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
    end
    rd_pend <= !sram_csb0 && sram_web0;
    rd_addr <= sram_addr0;
  end

  always @(negedge clk0) begin
    if (rd_pend) sram_dout0 <= mem[rd_addr];
  end

  task automatic chk_eq(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic drv(input logic v, input logic we,
                     input logic [3:0] m,
                     input logic [8:0] a,
                     input logic [31:0] d);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_wmask = m;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb0 = 1'b0;
    bus.rsp_ready = 1'b0;
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    #12;
    chk_eq("rst_csb", 64'(sram_csb0), 64'(1));
    chk_eq("rst_web", 64'(sram_web0), 64'(1));
    chk_eq("rst_wmask", 64'(sram_wmask0), 64'(0));
    chk_eq("rst_addr", 64'(sram_addr0), 64'(0));
    chk_eq("rst_din", 64'(sram_din0), 64'(0));
    chk_eq("rst_rspv", 64'(bus.rsp_valid), 64'(0));
    @(negedge clk0);
    rstb0 = 1'b1;
    step();
    chk_eq("rst_ready", 64'(bus.req_ready), 64'(1));
    chk_eq("idle_csb", 64'(sram_csb0), 64'(1));

    // Streaming reads 511,0,1,...: one response per cycle, pointers wrap.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drv(1, 0, 4'h0, 9'(511 + i), 32'h0);
      chk_eq("wrap_rdy", 64'(bus.req_ready), 64'(1));
      step();
      if (i >= 2) begin
        chk_eq("wrap_v", 64'(bus.rsp_valid), 64'(1));
        chk_eq("wrap_d", 64'(bus.rsp_rdata),
               64'(32'h5A00_0000 | 32'((511 + i - 2) % 512)));
      end
    end
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    chk_eq("wrap_d18", 64'(bus.rsp_rdata), 64'(32'h5A00_0011));
    step();
    chk_eq("wrap_d19", 64'(bus.rsp_rdata), 64'(32'h5A00_0012));
    step();
    chk_eq("wrap_end", 64'(bus.rsp_valid), 64'(0));

`ifndef SRAM_CTRL_WRITE_ACK_EN
    // Write then read back.
    drv(1, 1, 4'hF, 9'd5, 32'hDEAD_BEEF);
    chk_eq("wr_rdy", 64'(bus.req_ready), 64'(1));
    step();
    chk_eq("wr_csb", 64'(sram_csb0), 64'(0));
    chk_eq("wr_web", 64'(sram_web0), 64'(0));
    chk_eq("wr_mask", 64'(sram_wmask0), 64'(4'hF));
    chk_eq("wr_addr", 64'(sram_addr0), 64'(5));
    chk_eq("wr_din", 64'(sram_din0), 64'(32'hDEAD_BEEF));
    drv(1, 0, 4'hF, 9'd5, 32'h0);
    step();
    chk_eq("rd_csb", 64'(sram_csb0), 64'(0));
    chk_eq("rd_web", 64'(sram_web0), 64'(1));
    chk_eq("rd_mask", 64'(sram_wmask0), 64'(0));
    chk_eq("rd_v0", 64'(bus.rsp_valid), 64'(0));
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    chk_eq("rd_csb_hi", 64'(sram_csb0), 64'(1));
    chk_eq("rd_v1", 64'(bus.rsp_valid), 64'(0));
    step();
    chk_eq("rd_v2", 64'(bus.rsp_valid), 64'(1));
    chk_eq("rd_data", 64'(bus.rsp_rdata), 64'(32'hDEAD_BEEF));
    step();
    chk_eq("rd_pop", 64'(bus.rsp_valid), 64'(0));

    // Byte-lane mask.
    drv(1, 1, 4'hF, 9'd7, 32'h1122_3344);
    step();
    drv(1, 1, 4'h5, 9'd7, 32'hAABB_CCDD);
    step();
    drv(1, 0, 4'h0, 9'd7, 32'h0);
    step();
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    chk_eq("mask_v1", 64'(bus.rsp_valid), 64'(0));
    step();
    chk_eq("mask_v2", 64'(bus.rsp_valid), 64'(1));
    chk_eq("mask_d", 64'(bus.rsp_rdata), 64'(32'h11BB_33DD));
    step();

    // Backpressure with addr 0..5 preloaded to value = addr.
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 4'hF, 9'(i), 32'(i));
      step();
    end
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv(1, 0, 4'h0, 9'(i), 32'h0);
      chk_eq("bp_rdy", 64'(bus.req_ready), 64'(i < 4));
      step();
    end
    drv(1, 1, 4'hF, 9'd100, 32'h64);
    chk_eq("bp_wr_rdy", 64'(bus.req_ready), 64'(1));
    step();
    drv(1, 0, 4'h0, 9'd4, 32'h0);
    chk_eq("bp_full", 64'(bus.req_ready), 64'(0));
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    chk_eq("bp_head", 64'(bus.rsp_rdata), 64'(0));
    step();
    chk_eq("bp_hold", 64'(bus.rsp_rdata), 64'(0));
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk_eq("bp_pv", 64'(bus.rsp_valid), 64'(1));
      chk_eq("bp_pd", 64'(bus.rsp_rdata), 64'(j));
      step();
    end
    chk_eq("bp_empty", 64'(bus.rsp_valid), 64'(0));
    drv(1, 0, 4'h0, 9'd4, 32'h0);
    chk_eq("bp_rdy4", 64'(bus.req_ready), 64'(1));
    step();
    drv(1, 0, 4'h0, 9'd5, 32'h0);
    step();
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    chk_eq("bp_d4", 64'(bus.rsp_rdata), 64'(4));
    step();
    chk_eq("bp_d5", 64'(bus.rsp_rdata), 64'(5));
    step();
    chk_eq("bp_done", 64'(bus.rsp_valid), 64'(0));
`else
    // Write ack then read data, in order.
    drv(1, 1, 4'hF, 9'd20, 32'h1234_5678);
    step();
    drv(1, 0, 4'h0, 9'd20, 32'h0);
    step();
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    chk_eq("ack_v", 64'(bus.rsp_valid), 64'(1));
    chk_eq("ack_isw", 64'(bus.rsp_is_write), 64'(1));
    chk_eq("ack_d", 64'(bus.rsp_rdata), 64'(0));
    step();
    chk_eq("ack_rv", 64'(bus.rsp_valid), 64'(1));
    chk_eq("ack_risw", 64'(bus.rsp_is_write), 64'(0));
    chk_eq("ack_rd", 64'(bus.rsp_rdata), 64'(32'h1234_5678));
    step();
    chk_eq("ack_end", 64'(bus.rsp_valid), 64'(0));
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 4'hF, 9'(40 + i), 32'(i));
      chk_eq("ack_wrdy", 64'(bus.req_ready), 64'(i < 4));
      step();
    end
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk_eq("ack_dv", 64'(bus.rsp_valid), 64'(1));
      chk_eq("ack_disw", 64'(bus.rsp_is_write), 64'(1));
      step();
    end
    chk_eq("ack_dend", 64'(bus.rsp_valid), 64'(0));
`endif

    // Reset with 2 reads in flight and 2 queued.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 4'h0, 9'(i), 32'h0);
      step();
    end
    chk_eq("mr_pre_v", 64'(bus.rsp_valid), 64'(1));
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    rstb0 = 1'b0;
    #1;
    chk_eq("mr_csb", 64'(sram_csb0), 64'(1));
    chk_eq("mr_rspv", 64'(bus.rsp_valid), 64'(0));
    step();
    rstb0 = 1'b1;
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    chk_eq("mr_ready", 64'(bus.req_ready), 64'(1));
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_eq("mr_stale", 64'(bus.rsp_valid), 64'(0));
    end
    drv(1, 0, 4'h0, 9'd300, 32'h0);
    step();
    drv(0, 0, 4'h0, 9'd0, 32'h0);
    step();
    chk_eq("mr_v1", 64'(bus.rsp_valid), 64'(0));
    step();
    chk_eq("mr_v2", 64'(bus.rsp_valid), 64'(1));
    chk_eq("mr_d", 64'(bus.rsp_rdata), 64'(32'h5A00_012C));
    step();
    chk_eq("mr_end", 64'(bus.rsp_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
